// File: rtl/msk_sharing_unmask_tx_if.sv
// Handshake bundle for msk_sharing_unmask_tx: sharing input side and unmasked word stream.
// The master drives the sharing and sinks the words; the slave is the unmask block.
interface msk_sharing_unmask_tx_if #(
  parameter int d         = 2,
  parameter int Nbits     = 128,
  parameter int SIZE_FEED = 32
);
  logic [d*Nbits-1:0]   sharing_in;
  logic                 sharing_in_valid;
  logic                 sharing_in_ready;
  logic [SIZE_FEED-1:0] data_out;
  logic                 data_out_valid;
  logic                 data_out_ready;
  logic                 data_out_last;

  modport master (
    output sharing_in, sharing_in_valid, data_out_ready,
    input  sharing_in_ready, data_out, data_out_valid, data_out_last
  );

  modport slave (
    input  sharing_in, sharing_in_valid, data_out_ready,
    output sharing_in_ready, data_out, data_out_valid, data_out_last
  );
endinterface

// File: rtl/msk_sharing_unmask_tx.sv
// Captures a full d-share sharing and streams the recombined value word by word.
// Optional MSK_TX_ZEROIZE_EN: shares of each sent word, and the final data_out, are wiped.
//
// state | meaning
// IDLE  | ready to capture a new sharing
// SEND  | streaming words; data_out holds word cnt
module msk_sharing_unmask_tx #(
  parameter int d         = 2,
  parameter int Nbits     = 128,
  parameter int SIZE_FEED = 32
) (
  input logic                   clk,
  input logic                   n_rst,
  msk_sharing_unmask_tx_if.slave bus
);
  localparam int NWORDS = Nbits / SIZE_FEED;
  localparam int CW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int WSH    = d * SIZE_FEED;
  localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [d*Nbits-1:0]   r_share;
  logic [SIZE_FEED-1:0] r_data;

  logic                 w_rdy;
  logic                 w_cap;
  logic                 w_hs;
  logic [CW-1:0]        w_idx;
  logic [WSH-1:0]       w_slice;
  logic [SIZE_FEED-1:0] w_word;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rdy       = 1'b0;
    case (r_state)
      IDLE: begin
        w_rdy = 1'b1;
        if (bus.sharing_in_valid) w_state_nxt = SEND;
      end
      SEND: begin
        if (bus.data_out_ready && (r_cnt == LAST)) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_cap = (r_state == IDLE) && bus.sharing_in_valid;
  assign w_hs  = (r_state == SEND) && bus.data_out_ready;

  // Only the shares of the word about to be loaded are ever recombined.
  assign w_idx   = (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
  assign w_slice = (r_state == IDLE) ? bus.sharing_in[0 +: WSH]
                                     : r_share[int'(w_idx)*WSH +: WSH];

  always_comb begin
    w_word = '0;
    for (int b = 0; b < SIZE_FEED; b++) w_word[b] = ^w_slice[b*d +: d];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt   <= '0;
      r_share <= '0;
      r_data  <= '0;
    end else if (w_cap) begin
      r_share <= bus.sharing_in;
      r_data  <= w_word;
      r_cnt   <= '0;
    end else if (w_hs) begin
      if (r_cnt != LAST) begin
        r_cnt  <= r_cnt + 1'b1;
        r_data <= w_word;
      end
`ifdef MSK_TX_ZEROIZE_EN
      r_share[int'(r_cnt)*WSH +: WSH] <= '0;
      if (r_cnt == LAST) r_data <= '0;
`endif
    end
  end

  assign bus.sharing_in_ready = w_rdy;
  assign bus.data_out         = r_data;
  assign bus.data_out_valid   = (r_state == SEND);
  assign bus.data_out_last    = (r_state == SEND) && (r_cnt == LAST);
endmodule

// File: tb/tb_msk_sharing_unmask_tx.sv
// Bench for msk_sharing_unmask_tx: a d=2/128-bit instance and a d=3/64-bit instance,
// checked against words taken directly from the unmasked value.
module tb_msk_sharing_unmask_tx;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  localparam logic [127:0] V0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  msk_sharing_unmask_tx_if #(.d(2), .Nbits(128), .SIZE_FEED(32)) a ();
  msk_sharing_unmask_tx_if #(.d(3), .Nbits(64),  .SIZE_FEED(32)) b ();

  msk_sharing_unmask_tx #(.d(2), .Nbits(128), .SIZE_FEED(32)) dut_a (.clk(clk), .n_rst(n_rst), .bus(a));
  msk_sharing_unmask_tx #(.d(3), .Nbits(64),  .SIZE_FEED(32)) dut_b (.clk(clk), .n_rst(n_rst), .bus(b));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Random masking: all shares but the last are random; the last makes the XOR equal the value bit.
  function automatic logic [255:0] mask2(input logic [127:0] v);
    logic [255:0] s;
    for (int j = 0; j < 128; j++) begin
      s[2*j]   = 1'($urandom_range(0, 1));
      s[2*j+1] = v[j] ^ s[2*j];
    end
    return s;
  endfunction

  function automatic logic [191:0] mask3(input logic [63:0] v);
    logic [191:0] s;
    for (int j = 0; j < 64; j++) begin
      s[3*j]   = 1'($urandom_range(0, 1));
      s[3*j+1] = 1'($urandom_range(0, 1));
      s[3*j+2] = v[j] ^ s[3*j] ^ s[3*j+1];
    end
    return s;
  endfunction

  function automatic logic [31:0] word_of(input logic [127:0] v, input int k);
    return v[k*32 +: 32];
  endfunction

  task automatic test_reset;
    checks++; if (a.sharing_in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", a.sharing_in_ready); end
    checks++; if (a.data_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", a.data_out_valid); end
    checks++; if (a.data_out_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b exp 0", a.data_out_last); end
    checks++; if (a.data_out !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", a.data_out); end
    checks++; if (dut_a.r_share !== 256'h0) begin errors++; $display("FAIL reset_share got %h exp 0", dut_a.r_share); end
  endtask

  // Capture v on the next edge and check the stream with the sink always ready.
  task automatic stream_a(input logic [127:0] v, input string nm);
    logic [255:0] sh;
    sh = mask2(v);
    a.sharing_in = sh; a.sharing_in_valid = 1'b1; a.data_out_ready = 1'b1;
    tick;
    a.sharing_in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (a.data_out !== word_of(v, k)) begin errors++; $display("FAIL %s_word%0d got %h exp %h", nm, k, a.data_out, word_of(v, k)); end
      checks++; if (a.data_out_valid !== 1'b1 || a.data_out_last !== (k == 3) || a.sharing_in_ready !== 1'b0) begin
        errors++; $display("FAIL %s_flags%0d got v%b l%b r%b exp v1 l%b r0", nm, k, a.data_out_valid, a.data_out_last, a.sharing_in_ready, k == 3);
      end
      tick;
    end
    checks++; if (a.sharing_in_ready !== 1'b1 || a.data_out_valid !== 1'b0 || a.data_out_last !== 1'b0) begin
      errors++; $display("FAIL %s_idle got r%b v%b l%b exp r1 v0 l0", nm, a.sharing_in_ready, a.data_out_valid, a.data_out_last);
    end
`ifdef MSK_TX_ZEROIZE_EN
    checks++; if (dut_a.r_share !== 256'h0 || a.data_out !== 32'h0) begin errors++; $display("FAIL %s_zeroize got share %h data %h exp 0", nm, dut_a.r_share, a.data_out); end
`else
    checks++; if (dut_a.r_share !== sh) begin errors++; $display("FAIL %s_share_kept got %h exp %h", nm, dut_a.r_share, sh); end
    checks++; if (a.data_out !== word_of(v, 3)) begin errors++; $display("FAIL %s_data_kept got %h exp %h", nm, a.data_out, word_of(v, 3)); end
`endif
  endtask

  task automatic test_stream;
    stream_a(V0, "stream");
  endtask

  task automatic test_backpressure;
    a.sharing_in = mask2(V0); a.sharing_in_valid = 1'b1; a.data_out_ready = 1'b1;
    tick;
    a.sharing_in_valid = 1'b0;
    tick;
    a.data_out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++; if (a.data_out !== 32'h8899AABB || a.data_out_last !== 1'b0 || a.data_out_valid !== 1'b1 || dut_a.r_cnt !== 2'd1) begin
        errors++; $display("FAIL bp_hold%0d got %h l%b v%b cnt%0d exp 8899aabb l0 v1 cnt1", c, a.data_out, a.data_out_last, a.data_out_valid, dut_a.r_cnt);
      end
      tick;
    end
    a.data_out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      checks++; if (a.data_out !== word_of(V0, k) || a.data_out_last !== (k == 3)) begin
        errors++; $display("FAIL bp_word%0d got %h l%b exp %h l%b", k, a.data_out, a.data_out_last, word_of(V0, k), k == 3);
      end
      tick;
    end
    checks++; if (a.sharing_in_ready !== 1'b1 || a.data_out_valid !== 1'b0) begin errors++; $display("FAIL bp_idle got r%b v%b exp r1 v0", a.sharing_in_ready, a.data_out_valid); end
  endtask

  task automatic test_ignore_valid;
    logic [127:0] va, vb;
    va = {$urandom, $urandom, $urandom, $urandom};
    vb = ~va;
    a.sharing_in = mask2(va); a.sharing_in_valid = 1'b1; a.data_out_ready = 1'b1;
    tick;
    a.sharing_in = mask2(vb); a.sharing_in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (a.data_out !== word_of(va, k)) begin errors++; $display("FAIL ignore_word%0d got %h exp %h", k, a.data_out, word_of(va, k)); end
      if (k == 1) a.sharing_in_valid = 1'b0;
      tick;
    end
    checks++; if (a.data_out_valid !== 1'b0) begin errors++; $display("FAIL ignore_idle got v%b exp v0", a.data_out_valid); end
  endtask

  task automatic test_random;
    logic [127:0] v;
    logic [31:0]  q[$];
    int           cyc;
    for (int it = 0; it < 6; it++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      q.delete();
      for (int k = 0; k < 4; k++) q.push_back(word_of(v, k));
      a.sharing_in = mask2(v); a.sharing_in_valid = 1'b1; a.data_out_ready = 1'b0;
      tick;
      a.sharing_in_valid = 1'b0;
      cyc = 0;
      while (q.size() > 0 && cyc < 100) begin
        a.data_out_ready = 1'($urandom_range(0, 1));
        checks++; if (a.data_out_valid !== 1'b1 || a.data_out !== q[0] || a.data_out_last !== (q.size() == 1)) begin
          errors++; $display("FAIL rand%0d got v%b %h l%b exp v1 %h l%b", it, a.data_out_valid, a.data_out, a.data_out_last, q[0], q.size() == 1);
        end
        if (a.data_out_ready) void'(q.pop_front());
        tick;
        cyc++;
      end
      checks++; if (q.size() != 0 || a.data_out_valid !== 1'b0 || a.sharing_in_ready !== 1'b1) begin
        errors++; $display("FAIL rand%0d_end got left %0d v%b r%b exp left 0 v0 r1", it, q.size(), a.data_out_valid, a.sharing_in_ready);
      end
    end
  endtask

  task automatic test_reset_mid;
    a.sharing_in = mask2(V0); a.sharing_in_valid = 1'b1; a.data_out_ready = 1'b1;
    tick;
    a.sharing_in_valid = 1'b0;
    tick;
    tick;
    #2 n_rst = 1'b0;
    #1;
    checks++; if (a.data_out_valid !== 1'b0 || a.data_out_last !== 1'b0 || a.data_out !== 32'h0 || a.sharing_in_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid got v%b l%b %h r%b exp v0 l0 0 r1", a.data_out_valid, a.data_out_last, a.data_out, a.sharing_in_ready);
    end
    tick;
    n_rst = 1'b1;
    tick;
    checks++; if (a.data_out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_after got v%b exp v0", a.data_out_valid); end
    stream_a(128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, "rstmid_new");
  endtask

  task automatic test_back_to_back;
    logic [63:0] va, vb;
    va = {$urandom, $urandom};
    vb = {$urandom, $urandom};
    checks++; if (b.sharing_in_ready !== 1'b1 || b.data_out_valid !== 1'b0) begin errors++; $display("FAIL b2b_reset got r%b v%b exp r1 v0", b.sharing_in_ready, b.data_out_valid); end
    b.sharing_in = mask3(va); b.sharing_in_valid = 1'b1; b.data_out_ready = 1'b1;
    tick;
    b.sharing_in = mask3(vb);
    checks++; if (b.data_out !== va[31:0] || b.data_out_last !== 1'b0) begin errors++; $display("FAIL b2b_a0 got %h l%b exp %h l0", b.data_out, b.data_out_last, va[31:0]); end
    tick;
    checks++; if (b.data_out !== va[63:32] || b.data_out_last !== 1'b1) begin errors++; $display("FAIL b2b_a1 got %h l%b exp %h l1", b.data_out, b.data_out_last, va[63:32]); end
    tick;
    checks++; if (b.data_out_valid !== 1'b0 || b.sharing_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_gap got v%b r%b exp v0 r1", b.data_out_valid, b.sharing_in_ready); end
    tick;
    b.sharing_in_valid = 1'b0;
    checks++; if (b.data_out_valid !== 1'b1 || b.data_out !== vb[31:0]) begin errors++; $display("FAIL b2b_b0 got v%b %h exp v1 %h", b.data_out_valid, b.data_out, vb[31:0]); end
    tick;
    checks++; if (b.data_out !== vb[63:32] || b.data_out_last !== 1'b1) begin errors++; $display("FAIL b2b_b1 got %h l%b exp %h l1", b.data_out, b.data_out_last, vb[63:32]); end
    tick;
    checks++; if (b.data_out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got v%b exp v0", b.data_out_valid); end
  endtask

  initial begin
    a.sharing_in = '0; a.sharing_in_valid = 1'b0; a.data_out_ready = 1'b0;
    b.sharing_in = '0; b.sharing_in_valid = 1'b0; b.data_out_ready = 1'b0;
    #12;
    test_reset;
    tick;
    n_rst = 1'b1;
    tick;
    test_stream;
    test_backpressure;
    test_ignore_valid;
    test_random;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
